fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage that produces the fetch/decode pipeline register's inputs: instruction, PC, PC+4, and its write enable. Owns the fetch PC. Issues requests to instruction memory over a req/ready handshake. Buffers responses so that decode stalls lose nothing. Handles branch/jump redirects from EX, including a request already in flight, and writes a NOP into the fetch/decode register to squash the wrong-path instruction.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset.
- NOP, 32'h0000_0013: instruction word written on squash (addi x0,x0,0).

Ports (clock and reset first):
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  response; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction.
- stall  in  1  hazard unit: hold fetch/decode register.
- redirect  in  1  EX: taken branch/jump; flush and refetch.
- redirect_pc  in  32  target address; valid when redirect=1.
- instructionOUT  out  32  to fetch/decode instructionIN.
- pcOUT  out  32  to fetch/decode pcIN.
- pcPlus4OUT  out  32  to fetch/decode pcPlus4IN (pcOUT+4, mod 2^32).
- fd_we  out  1  to fetch/decode we.

## Operation
- Storage:
  - fpc: next fetch PC.
  - Output slot: slot_v, slot_instr, slot_pc.
  - Skid entry: skid_instr, skid_pc.
  - drop_addr.
  - State: IDLE, FETCH, HOLD, DROP.
- Outputs:
  - pcOUT=slot_pc; pcPlus4OUT=slot_pc+4.
  - instructionOUT = redirect ? NOP : slot_instr.
  - fd_we = redirect | (slot_v & ~stall).
  - The slot is consumed when slot_v & ~stall & ~redirect.
- Request signals:
  - imem_req=1 in FETCH and DROP only.
  - imem_addr=fpc in FETCH, drop_addr in DROP.
- State transitions (redirect handling below):
  - IDLE: go to FETCH.
  - FETCH, imem_ready=1:
    - If slot empty or consumed this cycle: load slot with {imem_rdata, fpc}, fpc+=4, stay FETCH.
    - Otherwise: load skid with {imem_rdata, fpc}, fpc+=4, go to HOLD.
  - FETCH, imem_ready=0: stay.
  - HOLD: request deasserted. When the slot is consumed, skid moves into the slot; go to FETCH.
  - DROP: on imem_ready, discard the response and go to FETCH.
- Redirect (highest priority, any state): slot_v<=0, fpc<=redirect_pc, skid discarded. Then:
  - FETCH with imem_ready=1: discard the response, stay FETCH.
  - FETCH with imem_ready=0: drop_addr<=fpc (old), go to DROP.
  - DROP: stay DROP; drop_addr unchanged; fpc takes the newest target.
  - IDLE or HOLD: go to FETCH.
- A redirect wins over a simultaneous stall: fd_we=1 with NOP, so the wrong-path fetch/decode entry is overwritten.
- fpc and PC+4 arithmetic: 32-bit, wrap 32'hFFFF_FFFC -> 0. No alignment check.

## Timing
- Reset (asynchronous):
  - state=IDLE, fpc=RESET_PC, slot_v=0, slot_instr=NOP, slot_pc=RESET_PC.
  - Outputs: imem_req=0, instructionOUT=NOP, pcOUT=RESET_PC, pcPlus4OUT=RESET_PC+4, fd_we=0 (with redirect=0).
- Reset asserted mid-request abandons the request. The memory must tolerate imem_req dropping.
- After reset release: IDLE for 1 cycle, then imem_req=1 with RESET_PC.
- Latency: response accepted in cycle N → slot valid and fd_we=1 in N+1 (no stall).
- Throughput: 1 instruction/cycle with zero-wait memory.
- At most two fetched instructions are held (slot + skid). No request is issued in HOLD.
- Redirect at cycle N: fd_we=1 with NOP in cycle N. With zero-wait memory, the first request to redirect_pc is at N+1 and its instruction reaches the outputs at N+2. In DROP, the target request starts the cycle after the dropped response.
- Stall held indefinitely: outputs frozen, fd_we=0, no instruction lost or duplicated.

## Test plan
- Reset, zero-wait memory returning addr-as-data:
  - imem_addr=0,4,8 on consecutive cycles from cycle 2.
  - fd_we=1 from cycle 3 with pcOUT=0,4,8 and pcPlus4OUT=4,8,12.
- Stall raised for 3 cycles while slot holds pc 8:
  - One more response (pc 12) goes to skid; imem_req=0 in HOLD; fd_we=0 for 3 cycles.
  - After release: pc 8, then 12, then 16, no gaps or repeats.
- Memory with 3-cycle wait, redirect to 0x100 at wait cycle 1:
  - imem_addr holds the old value until ready; that response is discarded.
  - Next request is 0x100; fd_we=1 with NOP in the redirect cycle.
- Redirect and stall in the same cycle with slot valid: fd_we=1, instructionOUT=0x00000013; next accepted pcOUT=target.
- Two redirects (0x200, then 0x300) while in DROP: only 0x300 is fetched after the dropped response.
- RESET_PC=32'hFFFF_FFFC: pcPlus4OUT=0, next imem_addr=0. Also, reset_n asserted mid-wait: all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// The fetch unit drives req/addr; the memory answers with ready/rdata in the same cycle.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, buffers up to two responses (slot + skid),
// and squashes the fetch/decode entry with a NOP on EX redirects, dropping any in-flight request.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset_n,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic [31:0]         instructionOUT,
  output logic [31:0]         pcOUT,
  output logic [31:0]         pcPlus4OUT,
  output logic                fd_we
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] fpc_r;
  logic        slot_v_r;
  logic [31:0] slot_instr_r;
  logic [31:0] slot_pc_r;
  logic [31:0] skid_instr_r;
  logic [31:0] skid_pc_r;
  logic [31:0] drop_addr_r;

  logic        consume_s;
  logic        accept_s;
  logic        to_slot_s;
  logic        to_skid_s;
  logic        skid_to_slot_s;
  logic        arm_drop_s;

  assign consume_s      = slot_v_r & ~stall & ~redirect;
  assign pcOUT          = slot_pc_r;
  assign pcPlus4OUT     = slot_pc_r + 32'd4;
  assign instructionOUT = redirect ? NOP : slot_instr_r;
  assign fd_we          = redirect | (slot_v_r & ~stall);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus the datapath strobes that go with each transition.
  always_comb begin
    state_nxt_s    = state_r;
    accept_s       = 1'b0;
    to_slot_s      = 1'b0;
    to_skid_s      = 1'b0;
    skid_to_slot_s = 1'b0;
    arm_drop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        state_nxt_s = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          if (imem.ready) begin
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = DROP;
            arm_drop_s  = 1'b1;
          end
        end else if (imem.ready) begin
          accept_s = 1'b1;
          if (!slot_v_r || consume_s) begin
            to_slot_s   = 1'b1;
            state_nxt_s = FETCH;
          end else begin
            to_skid_s   = 1'b1;
            state_nxt_s = HOLD;
          end
        end else begin
          state_nxt_s = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_nxt_s = FETCH;
        end else if (consume_s) begin
          skid_to_slot_s = 1'b1;
          state_nxt_s    = FETCH;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      DROP: begin
        // A newer redirect keeps us waiting on the same abandoned address.
        if (redirect) begin
          state_nxt_s = DROP;
        end else if (imem.ready) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Request outputs per state.
  always_comb begin
    imem.req  = 1'b0;
    imem.addr = fpc_r;
    case (state_r)
      FETCH: begin
        imem.req  = 1'b1;
        imem.addr = fpc_r;
      end
      DROP: begin
        imem.req  = 1'b1;
        imem.addr = drop_addr_r;
      end
      default: begin
        imem.req  = 1'b0;
        imem.addr = fpc_r;
      end
    endcase
  end

  // Fetch PC, output slot, skid entry and the address of an abandoned request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc_r        <= RESET_PC;
      slot_v_r     <= 1'b0;
      slot_instr_r <= NOP;
      slot_pc_r    <= RESET_PC;
      skid_instr_r <= NOP;
      skid_pc_r    <= RESET_PC;
      drop_addr_r  <= RESET_PC;
    end else if (redirect) begin
      fpc_r    <= redirect_pc;
      slot_v_r <= 1'b0;
      if (arm_drop_s) begin
        drop_addr_r <= fpc_r;
      end
    end else begin
      if (accept_s) begin
        fpc_r <= fpc_r + 32'd4;
      end
      if (to_slot_s) begin
        slot_v_r     <= 1'b1;
        slot_instr_r <= imem.rdata;
        slot_pc_r    <= fpc_r;
      end else if (skid_to_slot_s) begin
        slot_v_r     <= 1'b1;
        slot_instr_r <= skid_instr_r;
        slot_pc_r    <= skid_pc_r;
      end else if (consume_s) begin
        slot_v_r <= 1'b0;
      end
      if (to_skid_s) begin
        skid_instr_r <= imem.rdata;
        skid_pc_r    <= fpc_r;
      end
    end
  end

endmodule
